// File: rtl/float_adder_arbiter_if.sv
// rtl/float_adder_arbiter_if.sv - requester, response and adder signals of the shared float adder arbiter
interface float_adder_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // requester side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_op_a;
  logic [NUM_REQ*32-1:0] req_op_b;
  logic [NUM_REQ-1:0]    req_ready;
  // response side
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_result;
  logic                  resp_out_invalid;
  logic                  resp_in_invalid;
  logic                  resp_timeout;
  // adder side
  logic [31:0]           add_op1;
  logic [31:0]           add_op2;
  logic                  add_input_valid;
  logic [31:0]           add_result;
  logic                  add_result_valid;
  logic                  add_output_invalid;
  logic                  add_input_invalid;
  // status
  logic                  busy;
  logic [2:0]            grant_id;

  // arbiter view
  modport slave (
    input  req_valid, req_op_a, req_op_b,
    input  add_result, add_result_valid, add_output_invalid, add_input_invalid,
    output req_ready, resp_valid, resp_result, resp_out_invalid, resp_in_invalid, resp_timeout,
    output add_op1, add_op2, add_input_valid, busy, grant_id
  );

  // environment view: requesters plus the adder itself
  modport master (
    output req_valid, req_op_a, req_op_b,
    output add_result, add_result_valid, add_output_invalid, add_input_invalid,
    input  req_ready, resp_valid, resp_result, resp_out_invalid, resp_in_invalid, resp_timeout,
    input  add_op1, add_op2, add_input_valid, busy, grant_id
  );
endinterface

// File: rtl/float_adder_arbiter.sv
// rtl/float_adder_arbiter.sv - round-robin scheduler sharing one float adder with a watchdog
module float_adder_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  float_adder_arbiter_if.slave bus
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic              in_inv_q;
  logic              found;
  logic [2:0]        sel;
  logic [NUM_REQ-1:0] ready;

  // pick the first pending requester after the last grant, wrapping around
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = 3'd0;
    idx   = 0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      idx = (int'(ptr) + j) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  // accept strobe exists only in IDLE and is forced low while reset is held
  always_comb begin
    ready = '0;
    if (state == S_IDLE && rst_n && found) begin
      ready[sel] = 1'b1;
    end
  end

  assign bus.req_ready = ready;

  // single FSM: accept, launch, ignore stale level, wait with watchdog, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      ptr                  <= 3'(NUM_REQ - 1);
      wd_cnt               <= '0;
      in_inv_q             <= 1'b0;
      bus.add_op1          <= '0;
      bus.add_op2          <= '0;
      bus.add_input_valid  <= 1'b0;
      bus.resp_valid       <= '0;
      bus.resp_result      <= '0;
      bus.resp_out_invalid <= 1'b0;
      bus.resp_in_invalid  <= 1'b0;
      bus.resp_timeout     <= 1'b0;
      bus.busy             <= 1'b0;
      bus.grant_id         <= 3'd0;
    end else begin
      bus.add_input_valid <= 1'b0;
      bus.resp_valid      <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            bus.add_op1         <= bus.req_op_a[int'(sel)*32 +: 32];
            bus.add_op2         <= bus.req_op_b[int'(sel)*32 +: 32];
            bus.grant_id        <= sel;
            ptr                 <= sel;
            bus.busy            <= 1'b1;
            bus.add_input_valid <= 1'b1;
            state               <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          in_inv_q <= bus.add_input_invalid;
          state    <= S_GUARD;
        end
        S_GUARD: begin
          // the adder is still dropping the previous result level here
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.add_result_valid) begin
            bus.resp_result      <= bus.add_result;
            bus.resp_out_invalid <= bus.add_output_invalid;
            bus.resp_in_invalid  <= in_inv_q;
            bus.resp_timeout     <= 1'b0;
            bus.resp_valid       <= NUM_REQ'(1) << bus.grant_id;
            state                <= S_RESP;
          end else if (TIMEOUT_CYCLES != 0 && wd_cnt == WD_W'(TIMEOUT_CYCLES)) begin
            bus.resp_result      <= '0;
            bus.resp_out_invalid <= 1'b0;
            bus.resp_in_invalid  <= in_inv_q;
            bus.resp_timeout     <= 1'b1;
            bus.resp_valid       <= NUM_REQ'(1) << bus.grant_id;
            state                <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_adder_arbiter.sv
// tb/tb_float_adder_arbiter.sv - directed and randomized bench with adder stub and reference model
module tb_float_adder_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_adder_arbiter_if #(.NUM_REQ(N)) bus();

  float_adder_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int resp_count = 0;
  int ref_ptr = N - 1;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];

  // stub configuration and state
  int          mode_cfg = 0;   // 0 normal, 1 stale level, 2 hung
  int          lat_cfg = 1;
  int          s_mode = 0;
  int          s_lat = 1;
  int          k = 0;
  bit          launched = 1'b0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.resp_valid != '0) resp_count <= resp_count + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_op_a[i*32 +: 32] = op_a[i];
      bus.req_op_b[i*32 +: 32] = op_b[i];
    end
  end

  function automatic bit is_inv(input logic [31:0] x);
    return x[30:23] == 8'hFF;
  endfunction

  // known float sums, otherwise an integer signature of the operands
  function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + b;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r[30:23] = 8'hFF;
    return r;
  endfunction

  // adder stub: k counts edges since the launch edge; result level held until next launch
  always @(posedge clk) begin
    if (bus.add_input_valid) begin
      launched <= 1'b1;
      k        <= 1;
      s_a      <= bus.add_op1;
      s_b      <= bus.add_op2;
      s_mode   <= mode_cfg;
      s_lat    <= lat_cfg;
    end else if (launched && k < 100000) begin
      k <= k + 1;
    end
  end

  always_comb begin
    bus.add_result_valid   = 1'b0;
    bus.add_result         = '0;
    bus.add_output_invalid = 1'b0;
    bus.add_input_invalid  = is_inv(bus.add_op1) | is_inv(bus.add_op2);
    if (launched) begin
      if (s_mode == 0 && k >= 1 + s_lat) begin
        bus.add_result_valid   = 1'b1;
        bus.add_result         = stub_sum(s_a, s_b);
        bus.add_output_invalid = is_inv(s_a) | is_inv(s_b);
      end else if (s_mode == 1 && k == 1) begin
        bus.add_result_valid = 1'b1;
        bus.add_result       = 32'hBAD0BAD0;
      end else if (s_mode == 1 && k >= 5) begin
        bus.add_result_valid   = 1'b1;
        bus.add_result         = stub_sum(s_a, s_b);
        bus.add_output_invalid = is_inv(s_a) | is_inv(s_b);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] v);
    for (int j = 1; j <= N; j++) begin
      if (v[(ref_ptr + j) % N]) return (ref_ptr + j) % N;
    end
    return -1;
  endfunction

  // one operation: present mask, check grant, follow to the response and check it
  task automatic serve(input logic [N-1:0] mask, input int mode, input int lat, input bit keep);
    int g, t0, n, k_c, want_d;
    bit stable;
    logic [31:0] a, b, want_res;
    bit in_inv;
    lat_cfg = lat;
    mode_cfg = mode;
    bus.req_valid = mask;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_seen", 64'(bus.req_ready != '0), 64'd1);
    if (bus.req_ready == '0) return;
    g = exp_grant(mask);
    chk("ready_onehot", 64'(bus.req_ready), 64'(1 << g));
    t0 = cyc;
    a = op_a[g];
    b = op_b[g];
    ref_ptr = g;
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid[g] = 1'b0;
    chk("grant_id", 64'(bus.grant_id), 64'(g));
    chk("issue_pulse", 64'(bus.add_input_valid), 64'd1);
    if (mode == 0) k_c = (1 + lat > 2) ? 1 + lat : 2;
    else if (mode == 1) k_c = 5;
    else k_c = 2 + TO;
    want_d = 2 + k_c;
    in_inv = is_inv(a) | is_inv(b);
    want_res = (mode == 2) ? 32'h0 : stub_sum(a, b);
    n = 0;
    stable = 1'b1;
    while (bus.resp_valid == '0 && n < 200) begin
      @(negedge clk);
      if (bus.resp_valid == '0 &&
          (bus.add_op1 !== a || bus.add_op2 !== b || bus.req_ready !== '0 || bus.busy !== 1'b1))
        stable = 1'b0;
      n++;
    end
    chk("resp_seen", 64'(bus.resp_valid != '0), 64'd1);
    chk("latency", 64'(cyc - t0), 64'(want_d));
    chk("resp_onehot", 64'(bus.resp_valid), 64'(1 << g));
    chk("resp_result", 64'(bus.resp_result), 64'(want_res));
    chk("resp_timeout", 64'(bus.resp_timeout), 64'(mode == 2));
    chk("resp_in_inv", 64'(bus.resp_in_invalid), 64'(in_inv));
    chk("resp_out_inv", 64'(bus.resp_out_invalid), 64'((mode != 2) && in_inv));
    chk("hold_while_busy", 64'(stable), 64'd1);
    @(negedge clk);
    chk("resp_pulse_end", 64'(bus.resp_valid), 64'd0);
    chk("resp_data_held", 64'(bus.resp_result), 64'(want_res));
    chk("idle_not_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int rc0, n;
    bus.req_valid = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    // reset state, including ready gated while reset is held
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_issue", 64'(bus.add_input_valid), 64'd0);
    chk("rst_op1", 64'(bus.add_op1), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single request on port 1: 1.0 + 2.0
    op_a[1] = 32'h3F800000;
    op_b[1] = 32'h40000000;
    serve(4'b0010, 0, 1, 1'b0);

    // infinity operand flags input invalid, arbiter keeps working
    op_a[2] = 32'h7F800000;
    op_b[2] = 32'h3F800000;
    serve(4'b0100, 0, 2, 1'b0);

    // randomized masks, operands and adder latency
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = rand_op();
        op_b[i] = rand_op();
      end
      serve(4'($urandom_range(1, 15)), 0, int'($urandom_range(1, 6)), 1'b0);
    end

    // stale result level through ISSUE/GUARD, real result three cycles after it clears
    op_a[3] = rand_op();
    op_b[3] = rand_op();
    serve(4'b1000, 1, 1, 1'b0);

    // hung adder: watchdog response, then normal service
    op_a[0] = rand_op();
    serve(4'b0001, 2, 1, 1'b0);
    op_a[1] = rand_op();
    serve(4'b0010, 0, 3, 1'b0);

    // reset while waiting on a hung adder
    mode_cfg = 2;
    op_a[2] = 32'h12345678;
    bus.req_valid = 4'b0100;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_accept", 64'(bus.req_ready), 64'b0100);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (10) @(negedge clk);
    chk("abort_busy_pre", 64'(bus.busy), 64'd1);
    bus.req_valid = '1;
    rc0 = resp_count;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_ready", 64'(bus.req_ready), 64'd0);
    chk("abort_op1", 64'(bus.add_op1), 64'd0);
    chk("abort_grant", 64'(bus.grant_id), 64'd0);
    chk("abort_result", 64'(bus.resp_result), 64'd0);
    chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = N - 1;

    // all requesters continuously valid from reset: 0,1,2,3,0
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = rand_op();
        op_b[i] = rand_op();
      end
      serve(4'b1111, 0, int'($urandom_range(1, 4)), 1'b1);
    end
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("no_aborted_resp", 64'(resp_count - rc0), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
